baud_frac_gen: RTL and testbench

BAUD_FRAC_GEN -- requirements
Module: baud_frac_gen

---
 rtl/uart_pkg.sv | 22 ++
 rtl/frac_accum.sv | 42 ++++
 rtl/baud_frac_gen.sv | 129 ++++++++++++
 tb/tb_baud_frac_gen.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                   |
// | Purpose  : Shared constants for the UART baud generator: oversample  |
// |            ratios, oversample-counter width and the minimum legal     |
// |            integer divisor.                                           |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int OS16        = 16;
  localparam int OS8         = 8;
  localparam int OS_CNT_W    = 4;
  localparam int DIV_INT_MIN = 2;

  // Terminal value of the oversample counter for the selected ratio.
  function automatic logic [OS_CNT_W-1:0] os_last(input logic os8);
    return os8 ? OS_CNT_W'(OS8 - 1) : OS_CNT_W'(OS16 - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frac_accum                                                 |
// | Purpose  : NB_FRAC-bit phase accumulator. Reports whether adding the  |
// |            fractional divisor to the current phase carries out; the   |
// |            sum (mod 2^NB_FRAC) is stored when a period completes.     |
// | Ports    : clk, reset (async, active-low)                             |
// |            clear  - force phase to zero (priority over step)          |
// |            step   - current period ends, store the new phase          |
// |            frac   - fractional divisor                                |
// |            carry  - current period is one clock longer                |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module frac_accum #(
  parameter int NB_FRAC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic [NB_FRAC-1:0] frac,
  output logic               carry
);

  logic [NB_FRAC-1:0] phase;
  logic [NB_FRAC:0]   sum;

  assign sum   = {1'b0, phase} + {1'b0, frac};
  assign carry = sum[NB_FRAC];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (step) begin
      phase <= sum[NB_FRAC-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/baud_frac_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : baud_frac_gen                                              |
// | Purpose  : Fractional baud-rate generator. Emits an oversample tick   |
// |            every div_int + div_frac/2^NB_FRAC clocks on average and a |
// |            bit tick every 16 (or 8) oversample ticks. New divisors    |
// |            are staged in a one-deep pending slot and take effect at   |
// |            a bit boundary, or immediately while disabled.             |
// | Ports    : clk, reset (async, active-low), enable                     |
// |            cfg_valid/cfg_ready handshake, cfg_div_int, cfg_div_frac,  |
// |            cfg_os8 - configuration input                              |
// |            tick_os, tick_bit - one-cycle ticks                        |
// |            cfg_err - pulse when a too-small divisor was clamped       |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module baud_frac_gen
  import uart_pkg::*;
#(
  parameter int NB_INT       = 16,
  parameter int NB_FRAC      = 4,
  parameter int RST_DIV_INT  = 651,
  parameter int RST_DIV_FRAC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [NB_INT-1:0]  cfg_div_int,
  input  logic [NB_FRAC-1:0] cfg_div_frac,
  input  logic               cfg_os8,
  output logic               tick_os,
  output logic               tick_bit,
  output logic               cfg_err
);

  // Active configuration and the pending slot
  logic [NB_INT-1:0]  div_int, pend_int;
  logic [NB_FRAC-1:0] div_frac, pend_frac;
  logic               os8, pend_os8, pend_valid;

  // Counters and registered ticks
  logic [NB_INT-1:0]   cnt;
  logic [OS_CNT_W-1:0] os_cnt;
  logic                tick_os_q, tick_bit_q, cfg_err_q;

  logic               carry, period_end, bit_end, apply, accept;
  logic [NB_INT-1:0]  period_last;

  // Last count of the current period: div_int-1, or div_int on a phase
  // carry. Never exceeds 2^NB_INT-1 since div_int >= 2 after clamping.
  assign period_last = div_int - NB_INT'(1) + NB_INT'(carry);
  assign period_end  = enable && (cnt == period_last);
  assign bit_end     = period_end && (os_cnt == os_last(os8));
  assign apply       = pend_valid && (bit_end || !enable);
  assign cfg_ready   = !pend_valid;
  assign accept      = cfg_valid && cfg_ready;

  // Gating with enable makes the ticks drop in the same cycle enable does.
  assign tick_os  = tick_os_q && enable;
  assign tick_bit = tick_bit_q && enable;
  assign cfg_err  = cfg_err_q;

  frac_accum #(
    .NB_FRAC (NB_FRAC)
  ) u_frac_accum (
    .clk   (clk),
    .reset (reset),
    .clear (apply || !enable),
    .step  (period_end),
    .frac  (div_frac),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      os_cnt     <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      os_cnt     <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
    end else begin
      tick_os_q  <= period_end;
      tick_bit_q <= bit_end;
      if (period_end) begin
        cnt    <= '0;
        // An apply while enabled only happens at bit_end, so wrapping
        // here also covers clearing the oversample count on apply.
        os_cnt <= bit_end ? '0 : os_cnt + OS_CNT_W'(1);
      end else begin
        cnt    <= cnt + NB_INT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_int    <= NB_INT'(RST_DIV_INT);
      div_frac   <= NB_FRAC'(RST_DIV_FRAC);
      os8        <= 1'b0;
      pend_int   <= '0;
      pend_frac  <= '0;
      pend_os8   <= 1'b0;
      pend_valid <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= accept && (cfg_div_int < NB_INT'(DIV_INT_MIN));
      // apply needs pend_valid and accept needs !pend_valid: exclusive
      if (apply) begin
        div_int    <= pend_int;
        div_frac   <= pend_frac;
        os8        <= pend_os8;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_int   <= (cfg_div_int < NB_INT'(DIV_INT_MIN)) ? NB_INT'(DIV_INT_MIN)
                                                          : cfg_div_int;
        pend_frac  <= cfg_div_frac;
        pend_os8   <= cfg_os8;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baud_frac_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_baud_frac_gen                                           |
// | Purpose  : Self-checking bench for baud_frac_gen. Expected ticks come |
// |            from the closed form: the m-th tick of a run lands on      |
// |            clock m*div_int + floor(m*div_frac/2^NB_FRAC).             |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_baud_frac_gen;

  localparam int NB_INT  = 16;
  localparam int NB_FRAC = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [NB_INT-1:0]  cfg_div_int = '0;
  logic [NB_FRAC-1:0] cfg_div_frac = '0;
  logic               cfg_os8 = 1'b0;
  logic               cfg_ready, tick_os, tick_bit, cfg_err;

  logic enable2 = 1'b0;
  logic tick_os2, tick_bit2, cfg_ready2, cfg_err2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  longint m_int, m_frac, m_os;        // active divisor / ratio
  bit     p_valid;
  longint p_int, p_frac, p_os;        // pending configuration
  longint n, m;                       // enabled clocks in this run, next tick index
  bit     e_os, e_bit, e_err, e_ready;

  always #5 clk = ~clk;

  baud_frac_gen #(
    .NB_INT(NB_INT), .NB_FRAC(NB_FRAC), .RST_DIV_INT(651), .RST_DIV_FRAC(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_os8(cfg_os8),
    .tick_os(tick_os), .tick_bit(tick_bit), .cfg_err(cfg_err)
  );

  // Narrow instance driven at its maximum divisor to exercise wrap-around.
  baud_frac_gen #(
    .NB_INT(4), .NB_FRAC(2), .RST_DIV_INT(15), .RST_DIV_FRAC(3)
  ) dut_small (
    .clk(clk), .reset(reset), .enable(enable2),
    .cfg_valid(1'b0), .cfg_ready(cfg_ready2),
    .cfg_div_int(4'd0), .cfg_div_frac(2'd0), .cfg_os8(1'b0),
    .tick_os(tick_os2), .tick_bit(tick_bit2), .cfg_err(cfg_err2)
  );

  task automatic model_reset();
    m_int = 651; m_frac = 1; m_os = 16;
    p_valid = 0; p_int = 0; p_frac = 0; p_os = 16;
    n = 0; m = 1;
    e_os = 0; e_bit = 0; e_err = 0; e_ready = 1;
  endtask

  // One clock: advance the model on the rising edge, return 1ns later.
  task automatic cycle();
    bit acc_now, app;
    @(posedge clk);
    cyc++;
    acc_now = cfg_valid && !p_valid;
    app = 0;
    e_os = 0; e_bit = 0;
    if (enable) begin
      n++;
      if (n == m * m_int + ((m * m_frac) >> NB_FRAC)) begin
        e_os  = 1;
        e_bit = ((m % m_os) == 0);
        m++;
        if (e_bit && p_valid) app = 1;
      end
    end else begin
      n = 0; m = 1;
      if (p_valid) app = 1;
    end
    if (app) begin
      m_int = p_int; m_frac = p_frac; m_os = p_os;
      n = 0; m = 1; p_valid = 0;
    end
    e_err = 0;
    if (acc_now) begin
      p_valid = 1;
      p_int   = (cfg_div_int < 2) ? 2 : longint'(cfg_div_int);
      p_frac  = longint'(cfg_div_frac);
      p_os    = cfg_os8 ? 8 : 16;
      e_err   = (cfg_div_int < 2);
    end
    e_ready = !p_valid;
    #1;
  endtask

  // Disable, flush anything pending, load a configuration; ends disabled.
  task automatic configure(input int di, input int df, input bit o8);
    enable = 0; cfg_valid = 0;
    cycle();
    cfg_div_int = NB_INT'(di); cfg_div_frac = NB_FRAC'(df); cfg_os8 = o8;
    cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    cycle();
  endtask

  task automatic test_reset();
    #1 reset = 0;
    #1;
    checks++;
    if ({tick_os, tick_bit, cfg_err, cfg_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0001", {tick_os, tick_bit, cfg_err, cfg_ready});
    end
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    cycle();
    checks++;
    if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", {tick_os, tick_bit, cfg_ready, cfg_err},
               {e_os, e_bit, e_ready, e_err});
    end
  endtask

  task automatic test_integer();
    int last_os, last_bit;
    configure(10, 0, 0);
    enable = 1; last_os = cyc; last_bit = cyc;
    for (int i = 0; i < 330; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL integer_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
      if (tick_os) begin
        checks++;
        if (cyc - last_os != 10) begin
          errors++; $display("FAIL integer_os_period got=%0d exp=10", cyc - last_os);
        end
        last_os = cyc;
      end
      if (tick_bit) begin
        checks++;
        if (cyc - last_bit != 160) begin
          errors++; $display("FAIL integer_bit_period got=%0d exp=160", cyc - last_bit);
        end
        last_bit = cyc;
      end
    end
  endtask

  task automatic test_frac();
    int last_os, last_bit, k;
    configure(10, 8, 0);
    enable = 1; last_os = cyc; last_bit = cyc; k = 0;
    for (int i = 0; i < 350; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL frac_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
      if (tick_os) begin
        checks++;
        if (cyc - last_os != ((k % 2 == 0) ? 10 : 11)) begin
          errors++;
          $display("FAIL frac_os_period got=%0d exp=%0d", cyc - last_os, (k % 2 == 0) ? 10 : 11);
        end
        last_os = cyc; k++;
      end
      if (tick_bit) begin
        checks++;
        if (cyc - last_bit != 168) begin
          errors++; $display("FAIL frac_bit_period got=%0d exp=168", cyc - last_bit);
        end
        last_bit = cyc;
      end
    end
  endtask

  task automatic test_reconfig();
    bit got_bit;
    int last_bit, nbits;
    configure(10, 0, 0);
    enable = 1;
    for (int i = 0; i < 50; i++) cycle();
    cfg_div_int = 16'd4; cfg_div_frac = 4'd0; cfg_os8 = 1; cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    got_bit = 0; last_bit = 0; nbits = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL reconfig_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
      if (!got_bit && !tick_bit) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++; $display("FAIL reconfig_ready_low cyc=%0d got=%b exp=0", cyc, cfg_ready);
        end
      end
      if (tick_bit) begin
        if (got_bit) begin
          checks++; nbits++;
          if (cyc - last_bit != 32) begin
            errors++; $display("FAIL reconfig_bit_period got=%0d exp=32", cyc - last_bit);
          end
        end
        got_bit = 1; last_bit = cyc;
      end
    end
    checks++;
    if (nbits < 5) begin
      errors++; $display("FAIL reconfig_bit_count got=%0d exp>=5", nbits);
    end
  endtask

  task automatic test_clamp();
    int last_os, npulse;
    enable = 0; cfg_valid = 0;
    cycle();
    cfg_div_int = 16'd1; cfg_div_frac = 4'd0; cfg_os8 = 0; cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL clamp_err_pulse got=%b exp=1", cfg_err);
    end
    npulse = 0;
    enable = 1; last_os = cyc + 1;   // enable takes effect after the apply clock
    cycle();                         // apply clock (enable already 1, but pending flushes at bit end)
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL clamp_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
      if (cfg_err) npulse++;
    end
    // Enabled while the clamped config was still pending: it lands at the
    // first bit end, so verify its period once it is active.
    configure(1, 0, 0);
    enable = 1; last_os = cyc;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (cfg_err) npulse++;
      if (tick_os) begin
        checks++;
        if (cyc - last_os != 2) begin
          errors++; $display("FAIL clamp_os_period got=%0d exp=2", cyc - last_os);
        end
        last_os = cyc;
      end
    end
    checks++;
    if (npulse != 0) begin
      errors++; $display("FAIL clamp_err_once got=%0d extra pulses exp=0", npulse);
    end
  endtask

  task automatic test_enable_gap();
    int waited;
    configure(10, 0, 0);
    enable = 1;
    for (int i = 0; i < 25; i++) cycle();
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit} !== 2'b00 || {e_os, e_bit} !== 2'b00) begin
        errors++; $display("FAIL gap_no_ticks cyc=%0d got=%b exp=00", cyc, {tick_os, tick_bit});
      end
    end
    enable = 1; waited = 0;
    while (!tick_os && waited < 30) begin
      cycle(); waited++;
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL gap_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
    end
    checks++;
    if (waited != 10) begin
      errors++; $display("FAIL gap_first_tick got=%0d exp=10", waited);
    end
  endtask

  task automatic test_random();
    configure(4, 5, 1);
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_valid    = 1;
        cfg_div_int  = NB_INT'($urandom_range(0, 6));
        cfg_div_frac = NB_FRAC'($urandom);
        cfg_os8      = 1'($urandom_range(0, 1));
      end else begin
        cfg_valid = 0;
      end
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL random_outputs cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
    end
    cfg_valid = 0;
  endtask

  task automatic test_wrap();
    int start, mm;
    longint t_exp;
    bit hit;
    enable = 0; enable2 = 1; start = cyc; mm = 1;
    for (int i = 0; i < 270; i++) begin
      cycle();
      t_exp = longint'(mm) * 15 + ((longint'(mm) * 3) >> 2);
      hit = (longint'(cyc - start) == t_exp);
      checks++;
      if ({tick_os2, tick_bit2} !== {hit, hit && (mm % 16 == 0)}) begin
        errors++;
        $display("FAIL wrap_ticks t=%0d got=%b exp=%b", cyc - start, {tick_os2, tick_bit2},
                 {hit, hit && (mm % 16 == 0)});
      end
      if (hit) mm++;
    end
    checks++;
    if (mm != 18) begin
      errors++; $display("FAIL wrap_tick_count got=%0d exp=17", mm - 1);
    end
    checks++;
    if ({cfg_ready2, cfg_err2} !== 2'b10) begin
      errors++; $display("FAIL wrap_cfg_flags got=%b exp=10", {cfg_ready2, cfg_err2});
    end
    enable2 = 0;
  endtask

  task automatic test_async_reset();
    int waited;
    configure(3, 0, 0);
    enable = 1;
    for (int i = 0; i < 20; i++) cycle();
    cfg_div_int = 16'd5; cfg_valid = 1;
    cycle();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL areset_pending got=%b exp=0", cfg_ready);
    end
    waited = 0;
    while (!tick_os && waited < 10) begin
      cycle(); waited++;
    end
    checks++;
    if (tick_os !== 1'b1) begin
      errors++; $display("FAIL areset_tick_seen got=%b exp=1", tick_os);
    end
    #3 reset = 0;
    #1;
    checks++;
    if ({tick_os, tick_bit, cfg_err, cfg_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL areset_outputs got=%b exp=0001", {tick_os, tick_bit, cfg_err, cfg_ready});
    end
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if ({tick_os, tick_bit, cfg_ready, cfg_err} !== {e_os, e_bit, e_ready, e_err}) begin
        errors++;
        $display("FAIL areset_after cyc=%0d got=%b exp=%b", cyc,
                 {tick_os, tick_bit, cfg_ready, cfg_err}, {e_os, e_bit, e_ready, e_err});
      end
    end
    enable = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_integer();
    test_frac();
    test_reconfig();
    test_clamp();
    test_enable_gap();
    test_random();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
